// File: rtl/piezo_tone_decoder.sv
// Piezo tone decoder: measures rise-to-rise periods on the piezo drive pair,
// classifies them against the four fanfare notes and reports each completed note.
module piezo_tone_decoder #(
  parameter int PER_G6      = 31888,
  parameter int PER_C7      = 23889,
  parameter int PER_E7      = 18961,
  parameter int PER_G7      = 15944,
  parameter int PER_TOL     = 64,
  parameter int SILENCE_CYC = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        piezo,
  input  logic        piezo_n,
  output logic        note_vld,
  output logic [2:0]  note_id,
  output logic [15:0] note_periods,
  output logic [23:0] note_clks,
  output logic        busy,
  output logic        diff_err
);

  typedef enum logic [1:0] {IDLE, ARM, TONE} state_t;

  localparam logic signed [18:0] NOM_G6 = 19'(PER_G6);
  localparam logic signed [18:0] NOM_C7 = 19'(PER_C7);
  localparam logic signed [18:0] NOM_E7 = 19'(PER_E7);
  localparam logic signed [18:0] NOM_G7 = 19'(PER_G7);
  localparam logic signed [18:0] TOL_S  = 19'(PER_TOL);
  localparam logic [16:0]        SIL    = 17'(SILENCE_CYC);

  function automatic logic in_win(input logic [16:0] per, input logic signed [18:0] nom);
    logic signed [18:0] d;
    d = $signed({2'b00, per}) - nom;
    return (d >= -TOL_S) && (d <= TOL_S);
  endfunction

  function automatic logic [2:0] classify(input logic [16:0] per);
    logic [2:0] c;
    c = 3'd0;
    if (in_win(per, NOM_G6)) c = 3'd1;
    else if (in_win(per, NOM_C7)) c = 3'd2;
    else if (in_win(per, NOM_E7)) c = 3'd3;
    else if (in_win(per, NOM_G7)) c = 3'd4;
    return c;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  function automatic logic [23:0] sat_add24(input logic [23:0] acc, input logic [16:0] per);
    logic [24:0] s;
    s = {1'b0, acc} + {8'd0, per};
    return s[24] ? 24'hFFFFFF : s[23:0];
  endfunction

  // Stage p0/p1: two-flop synchronizers; p2: previous synced value for edge detect
  logic piezo_p0, piezo_p1, piezo_p2;
  logic piezo_n_p0, piezo_n_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      piezo_p0   <= 1'b0;
      piezo_p1   <= 1'b0;
      piezo_p2   <= 1'b0;
      piezo_n_p0 <= 1'b0;
      piezo_n_p1 <= 1'b0;
    end else begin
      piezo_p0   <= piezo;
      piezo_p1   <= piezo_p0;
      piezo_p2   <= piezo_p1;
      piezo_n_p0 <= piezo_n;
      piezo_n_p1 <= piezo_n_p0;
    end
  end

  logic rise, timeout, pair_eq;
  assign rise    = piezo_p1 & ~piezo_p2;
  assign pair_eq = (piezo_p1 == piezo_n_p1);

  // Period counter: holds clks since the last rise, saturating
  logic [16:0] cnt;
  assign timeout = !rise && (cnt == SIL);

  always_ff @(posedge clk) begin
    if (rst) cnt <= 17'd0;
    else if (rise) cnt <= 17'd1;
    else if (cnt != 17'h1FFFF) cnt <= cnt + 17'd1;
  end

  state_t      state, state_nx;
  logic [2:0]  cur_id, cur_id_nx, cls;
  logic [15:0] acc_per, acc_per_nx;
  logic [23:0] acc_clks, acc_clks_nx;
  logic        rpt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cur_id   <= 3'd0;
      acc_per  <= 16'd0;
      acc_clks <= 24'd0;
    end else begin
      state    <= state_nx;
      cur_id   <= cur_id_nx;
      acc_per  <= acc_per_nx;
      acc_clks <= acc_clks_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cur_id_nx   = cur_id;
    acc_per_nx  = acc_per;
    acc_clks_nx = acc_clks;
    rpt         = 1'b0;
    cls         = classify(cnt);
    case (state)
      IDLE: if (rise) state_nx = ARM;
      ARM: begin
        if (rise) begin
          if (cls != 3'd0) begin
            state_nx    = TONE;
            cur_id_nx   = cls;
            acc_per_nx  = 16'd1;
            acc_clks_nx = {7'd0, cnt};
          end
        end else if (timeout) begin
          state_nx = IDLE;
        end
      end
      TONE: begin
        if (rise) begin
          if (cls == cur_id) begin
            acc_per_nx  = sat_inc16(acc_per);
            acc_clks_nx = sat_add24(acc_clks, cnt);
          end else begin
            // A different note (or noise) ends the current one
            rpt = 1'b1;
            if (cls != 3'd0) begin
              cur_id_nx   = cls;
              acc_per_nx  = 16'd1;
              acc_clks_nx = {7'd0, cnt};
            end else begin
              state_nx = ARM;
            end
          end
        end else if (timeout) begin
          rpt      = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Report registers: strobe plus held note fields
  always_ff @(posedge clk) begin
    if (rst) begin
      note_vld     <= 1'b0;
      note_id      <= 3'd0;
      note_periods <= 16'd0;
      note_clks    <= 24'd0;
    end else begin
      note_vld <= rpt;
      if (rpt) begin
        note_id      <= cur_id;
        note_periods <= acc_per;
        note_clks    <= acc_clks;
      end
    end
  end

  // Differential fault: third consecutive equal cycle while busy, once per episode
  logic [1:0] eq_run;
  logic       fired;

  always_ff @(posedge clk) begin
    if (rst) begin
      eq_run   <= 2'd0;
      fired    <= 1'b0;
      diff_err <= 1'b0;
    end else begin
      diff_err <= 1'b0;
      if (!pair_eq) begin
        eq_run <= 2'd0;
        fired  <= 1'b0;
      end else begin
        if (eq_run != 2'd3) eq_run <= eq_run + 2'd1;
        if (eq_run >= 2'd2 && busy && !fired) begin
          diff_err <= 1'b1;
          fired    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_piezo_tone_decoder.sv
// Bench for piezo_tone_decoder: scaled note periods, directed scenarios plus
// random note streams, compared every cycle against an edge-indexed note model.
module tb_piezo_tone_decoder;
  localparam int P_G6 = 320;
  localparam int P_C7 = 240;
  localparam int P_E7 = 190;
  localparam int P_G7 = 160;
  localparam int TOL  = 4;
  localparam int SIL  = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        piezo = 1'b0;
  logic        piezo_n = 1'b1;
  logic        note_vld;
  logic [2:0]  note_id;
  logic [15:0] note_periods;
  logic [23:0] note_clks;
  logic        busy;
  logic        diff_err;

  piezo_tone_decoder #(
    .PER_G6(P_G6), .PER_C7(P_C7), .PER_E7(P_E7), .PER_G7(P_G7),
    .PER_TOL(TOL), .SILENCE_CYC(SIL)
  ) dut (
    .clk(clk), .rst(rst), .piezo(piezo), .piezo_n(piezo_n),
    .note_vld(note_vld), .note_id(note_id), .note_periods(note_periods),
    .note_clks(note_clks), .busy(busy), .diff_err(diff_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: pin samples per clock edge; synced value seen at edge n is pin(n-2)
  int     edge_n = 0;
  bit     ph[4];
  bit     pnh[4];
  int     st = 0;              // 0 idle, 1 armed, 2 in a note
  int     last_rise = 0;
  int     cur = 0;
  longint nper = 0, nclks = 0;
  bit     m_vld = 0, m_derr = 0;
  int     m_id = 0;
  longint m_per = 0, m_clks = 0;
  int     eq_start = -1;
  bit     flagged = 0;
  int     q_id[$];
  longint q_per[$], q_clks[$];
  int     q_gap[$];

  function automatic int cls_of(input int per);
    int nom[4];
    nom = '{P_G6, P_C7, P_E7, P_G7};
    for (int k = 0; k < 4; k++)
      if (per >= nom[k] - TOL && per <= nom[k] + TOL) return k + 1;
    return 0;
  endfunction

  task automatic report(input int gap);
    m_vld  = 1;
    m_id   = cur;
    m_per  = (nper > 65535) ? 65535 : nper;
    m_clks = (nclks > 16777215) ? 16777215 : nclks;
    q_id.push_back(m_id);
    q_per.push_back(m_per);
    q_clks.push_back(m_clks);
    q_gap.push_back(gap);
  endtask

  task automatic model_step();
    bit r, eq;
    int per, c;
    edge_n++;
    if (rst) begin
      for (int k = 0; k < 4; k++) begin ph[k] = 0; pnh[k] = 0; end
      st = 0; cur = 0; nper = 0; nclks = 0;
      m_vld = 0; m_id = 0; m_per = 0; m_clks = 0; m_derr = 0;
      eq_start = -1; flagged = 0;
      return;
    end
    for (int k = 3; k > 0; k--) begin ph[k] = ph[k-1]; pnh[k] = pnh[k-1]; end
    ph[0]  = piezo;
    pnh[0] = piezo_n;
    r  = ph[2] && !ph[3];
    eq = (ph[2] == pnh[2]);
    m_vld  = 0;
    m_derr = 0;
    if (!eq) begin
      eq_start = -1;
      flagged  = 0;
    end else begin
      if (eq_start < 0) eq_start = edge_n;
      if (edge_n - eq_start >= 2 && st != 0 && !flagged) begin
        m_derr  = 1;
        flagged = 1;
      end
    end
    if (r) begin
      per = edge_n - last_rise;
      c   = cls_of(per);
      if (st == 0) st = 1;
      else if (st == 1) begin
        if (c != 0) begin st = 2; cur = c; nper = 1; nclks = per; end
      end else begin
        if (c == cur) begin nper++; nclks += per; end
        else begin
          report(per);
          if (c != 0) begin cur = c; nper = 1; nclks = per; end
          else st = 1;
        end
      end
      last_rise = edge_n;
    end else if (st != 0 && edge_n - last_rise == SIL) begin
      if (st == 2) report(SIL);
      st = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  bit cmp_en = 0;
  int dut_vld_cnt = 0;
  int dut_derr_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("note_vld", 64'(note_vld), 64'(m_vld));
      chk("note_id", 64'(note_id), 64'(m_id));
      chk("note_periods", 64'(note_periods), 64'(m_per));
      chk("note_clks", 64'(note_clks), 64'(m_clks));
      chk("busy", 64'(busy), 64'(st != 0));
      chk("diff_err", 64'(diff_err), 64'(m_derr));
      if (note_vld === 1'b1) dut_vld_cnt++;
      if (diff_err === 1'b1) dut_derr_cnt++;
    end
  end

  task automatic period(input int p, input bit fault);
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      piezo   = (i < p / 2);
      piezo_n = (fault && i >= 10 && i < 20) ? piezo : ~piezo;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      piezo   = 1'b0;
      piezo_n = 1'b1;
    end
  endtask

  task automatic expect_note(input string nm, input int idx, input int id,
                             input longint per, input longint clks, input int gap);
    if (q_id.size() <= idx) begin
      chk({nm, "_present"}, 64'(q_id.size()), 64'(idx + 1));
    end else begin
      chk({nm, "_id"}, 64'(q_id[idx]), 64'(id));
      chk({nm, "_periods"}, 64'(q_per[idx]), 64'(per));
      chk({nm, "_clks"}, 64'(q_clks[idx]), 64'(clks));
      chk({nm, "_gap"}, 64'(q_gap[idx]), 64'(gap));
    end
  endtask

  initial begin
    int base, v0, d0;
    int cls, len, p, nom[5];
    nom = '{0, P_G6, P_C7, P_E7, P_G7};
    @(posedge clk);
    #1 cmp_en = 1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_note_id", 64'(note_id), 64'd0);
    rst = 1'b0;

    // Quiet pair: nothing may happen
    idle(3000);
    chk("quiet_vld_cnt", 64'(dut_vld_cnt), 64'd0);
    chk("quiet_derr_cnt", 64'(dut_derr_cnt), 64'd0);
    chk("quiet_note_id", 64'(note_id), 64'd0);

    // G6, 10 rises -> 9 periods, ended by silence
    base = q_id.size(); v0 = dut_vld_cnt;
    repeat (10) period(P_G6, 0);
    idle(1200);
    expect_note("g6", base, 1, 9, 2880, SIL);
    chk("g6_vld_cnt", 64'(dut_vld_cnt - v0), 64'd1);
    chk("g6_busy_after", 64'(busy), 64'd0);

    // C7 8 periods then E7 5 periods
    base = q_id.size(); v0 = dut_vld_cnt;
    repeat (8) period(P_C7, 0);
    repeat (6) period(P_E7, 0);
    idle(1200);
    expect_note("c7", base, 2, 8, 1920, P_E7);
    expect_note("e7", base + 1, 3, 5, 950, SIL);
    chk("c7e7_vld_cnt", 64'(dut_vld_cnt - v0), 64'd2);

    // Tolerance edge: +TOL accepted, +TOL+1 never leaves ARM
    base = q_id.size(); v0 = dut_vld_cnt;
    repeat (4) period(P_G7 + TOL, 0);
    idle(1200);
    expect_note("g7_tol", base, 4, 3, 3 * (P_G7 + TOL), SIL);
    v0 = dut_vld_cnt;
    repeat (4) period(P_G7 + TOL + 1, 0);
    idle(1200);
    chk("g7_out_vld_cnt", 64'(dut_vld_cnt - v0), 64'd0);
    chk("g7_out_busy", 64'(busy), 64'd0);

    // Differential fault mid-note
    base = q_id.size(); d0 = dut_derr_cnt;
    repeat (3) period(P_G7, 0);
    period(P_G7, 1);
    repeat (4) period(P_G7, 0);
    idle(1200);
    chk("fault_derr_cnt", 64'(dut_derr_cnt - d0), 64'd1);
    expect_note("g7_fault", base, 4, 7, 7 * P_G7, SIL);

    // Reset mid-note discards the partial note
    base = q_id.size(); v0 = dut_vld_cnt;
    repeat (6) period(P_E7, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_vld", 64'(note_vld), 64'd0);
    chk("midrst_periods", 64'(note_periods), 64'd0);
    rst = 1'b0;
    repeat (4) period(P_E7, 0);
    idle(1200);
    chk("midrst_vld_cnt", 64'(dut_vld_cnt - v0), 64'd1);
    expect_note("e7_fresh", base, 3, 3, 3 * P_E7, SIL);

    // Random note streams with occasional gaps and faults
    for (int s = 0; s < 30; s++) begin
      cls = $urandom_range(0, 4);
      len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) begin
        if (cls == 0) begin
          p = nom[$urandom_range(1, 4)];
          p = ($urandom_range(0, 1) != 0) ? p + TOL + 1 + $urandom_range(0, 10)
                                          : p - TOL - 1 - $urandom_range(0, 10);
        end else begin
          p = nom[cls] + $urandom_range(0, 2 * TOL) - TOL;
        end
        period(p, $urandom_range(0, 15) == 0);
      end
      if ($urandom_range(0, 3) == 0) idle(1100);
    end
    idle(1200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
